// File: rtl/audio_i2s_rx.sv
`timescale 1ns/1ps
// I2S ADC-side receiver for the WM8731: synchronizes BCLK/LRCK/ADCDAT into Clk and emits left/right pairs.
// Define AUDIO_RX_PEAK_EN to add the running left-channel peak detector on port peak_left.
module audio_i2s_rx #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_ADCLRCK,
    input  logic                  AUD_ADCDAT,
    output logic [DATA_WIDTH-1:0] sample_left,
    output logic [DATA_WIDTH-1:0] sample_right,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  overrun,
    output logic                  frame_err
`ifdef AUDIO_RX_PEAK_EN
    ,
    output logic [DATA_WIDTH-1:0] peak_left
`endif
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {ST_HUNT, ST_SKIP, ST_SHIFT, ST_WAIT} state_t;

    logic [SYNC_STAGES-1:0] r_bclkSync, r_lrSync, r_datSync;
    logic                   r_bclkPrev, r_lrPrev;
    logic                   w_bclk, w_lr, w_dat, w_bclkRise, w_lrEdge;

    state_t                 r_state, w_stateNext;
    logic                   r_slot, w_slotNext, w_newSlot, w_toSkip;
    logic [CW-1:0]          r_bitCnt, w_cntNext;
    logic [DATA_WIDTH-1:0]  r_shreg, w_shregNext, w_shifted;
    logic [DATA_WIDTH-1:0]  r_leftHold, w_leftHoldNext;
    logic                   w_frameDone, w_frameErr, w_load;

    logic [DATA_WIDTH-1:0]  r_sampleLeft, r_sampleRight;
    logic                   r_valid, r_overrun, r_frameErr;

    // All three pins share the same chain depth so their relative timing is preserved.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_bclkSync <= '0;
            r_lrSync   <= '0;
            r_datSync  <= '0;
            r_bclkPrev <= 1'b0;
            r_lrPrev   <= 1'b0;
        end else begin
            r_bclkSync <= {r_bclkSync[SYNC_STAGES-2:0], AUD_BCLK};
            r_lrSync   <= {r_lrSync[SYNC_STAGES-2:0], AUD_ADCLRCK};
            r_datSync  <= {r_datSync[SYNC_STAGES-2:0], AUD_ADCDAT};
            r_bclkPrev <= w_bclk;
            r_lrPrev   <= w_lr;
        end
    end

    assign w_bclk     = r_bclkSync[SYNC_STAGES-1];
    assign w_lr       = r_lrSync[SYNC_STAGES-1];
    assign w_dat      = r_datSync[SYNC_STAGES-1];
    assign w_bclkRise = w_bclk & ~r_bclkPrev;
    assign w_lrEdge   = w_lr ^ r_lrPrev;
    assign w_shifted  = {r_shreg[DATA_WIDTH-2:0], w_dat};

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state    <= ST_HUNT;
            r_slot     <= 1'b0;
            r_bitCnt   <= '0;
            r_shreg    <= '0;
            r_leftHold <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_slot     <= w_slotNext;
            r_bitCnt   <= w_cntNext;
            r_shreg    <= w_shregNext;
            r_leftHold <= w_leftHoldNext;
        end
    end

    // LRCK edges take priority; a coincident BCLK rise is consumed as the new slot's delay bit.
    always_comb begin
        w_stateNext    = r_state;
        w_slotNext     = r_slot;
        w_cntNext      = r_bitCnt;
        w_shregNext    = r_shreg;
        w_leftHoldNext = r_leftHold;
        w_frameDone    = 1'b0;
        w_frameErr     = 1'b0;
        w_toSkip       = 1'b0;
        w_newSlot      = r_slot;
        if (w_lrEdge) begin
            case (r_state)
                ST_HUNT: begin
                    if (!w_lr) begin
                        w_toSkip  = 1'b1;
                        w_newSlot = 1'b0;
                    end
                end
                ST_WAIT: begin
                    w_toSkip  = 1'b1;
                    w_newSlot = w_lr;
                end
                default: begin
                    w_frameErr     = 1'b1;
                    w_leftHoldNext = '0;
                    if (!w_lr) begin
                        w_toSkip  = 1'b1;
                        w_newSlot = 1'b0;
                    end else begin
                        w_stateNext = ST_HUNT;
                    end
                end
            endcase
        end else if (w_bclkRise) begin
            case (r_state)
                ST_SKIP: begin
                    w_stateNext = ST_SHIFT;
                    w_cntNext   = '0;
                end
                ST_SHIFT: begin
                    w_shregNext = w_shifted;
                    w_cntNext   = r_bitCnt + CW'(1);
                    if (r_bitCnt == CW'(DATA_WIDTH - 1)) begin
                        w_stateNext = ST_WAIT;
                        if (!r_slot) begin
                            w_leftHoldNext = w_shifted;
                        end else begin
                            w_frameDone = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
        if (w_toSkip) begin
            w_slotNext  = w_newSlot;
            w_cntNext   = '0;
            w_stateNext = w_bclkRise ? ST_SHIFT : ST_SKIP;
        end
    end

    assign w_load = w_frameDone & (~r_valid | sample_ready);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_sampleLeft  <= '0;
            r_sampleRight <= '0;
            r_valid       <= 1'b0;
            r_overrun     <= 1'b0;
            r_frameErr    <= 1'b0;
        end else begin
            r_overrun  <= 1'b0;
            r_frameErr <= w_frameErr;
            if (w_load) begin
                r_sampleLeft  <= r_leftHold;
                r_sampleRight <= w_shifted;
                r_valid       <= 1'b1;
            end else if (w_frameDone) begin
                r_overrun <= 1'b1;
            end else if (r_valid && sample_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign sample_left  = r_sampleLeft;
    assign sample_right = r_sampleRight;
    assign sample_valid = r_valid;
    assign overrun      = r_overrun;
    assign frame_err    = r_frameErr;

`ifdef AUDIO_RX_PEAK_EN
    logic [DATA_WIDTH-1:0] r_peak, w_absLeft, w_negLeft;
    logic                  r_readyRun, r_clrArm, w_idleReady;

    assign w_idleReady = sample_ready & ~r_valid;
    assign w_negLeft   = ~r_leftHold + DATA_WIDTH'(1);

    // The most negative value has no positive twin, so its magnitude clips to the largest positive.
    always_comb begin
        w_absLeft = r_leftHold;
        if (r_leftHold[DATA_WIDTH-1]) begin
            w_absLeft = w_negLeft[DATA_WIDTH-1] ? {1'b0, {(DATA_WIDTH-1){1'b1}}} : w_negLeft;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_peak     <= '0;
            r_readyRun <= 1'b0;
            r_clrArm   <= 1'b0;
        end else begin
            r_readyRun <= w_idleReady;
            if (w_idleReady && r_readyRun) begin
                r_clrArm <= 1'b1;
            end
            if (w_load) begin
                r_clrArm <= 1'b0;
                if (r_clrArm || (w_absLeft > r_peak)) begin
                    r_peak <= w_absLeft;
                end
            end
        end
    end

    assign peak_left = r_peak;
`endif

endmodule
